// File: rtl/mem_pkg.sv
// mem_pkg: constants and FSM encoding shared by the PSRAM arbiter and the
// memory controller (bank/address/data widths, timeout read value).
package mem_pkg;

   localparam int BANK_W = 6;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam int GID_W  = 2;

   // Read data returned to a requester whose command was never accepted.
   localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: combinational winner selection among pending requests.
// Build option MEM_ARB_ROUND_ROBIN_EN: when defined, a rotating priority
// pointer is kept here; otherwise the lowest set index always wins.
module mem_arb_select
   import mem_pkg::*;
#(
   parameter int NUM_REQ = 3
)
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic               clk,
   input  logic               reset,
   input  logic               grant_i,
`endif
   input  logic [NUM_REQ-1:0] req_i,
   output logic               valid_o,
   output logic [GID_W-1:0]   win_o
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic [GID_W-1:0] ptr_q;

   // First pass searches at/after the pointer, second pass wraps to index 0.
   always_comb begin
      valid_o = 1'b0;
      win_o   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!valid_o && req_i[k] && (k >= int'(ptr_q))) begin
            valid_o = 1'b1;
            win_o   = k[GID_W-1:0];
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!valid_o && req_i[k]) begin
            valid_o = 1'b1;
            win_o   = k[GID_W-1:0];
         end
      end
   end

   // After a grant to g, the pointer moves to (g+1) mod NUM_REQ.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else if (grant_i) begin
         if (int'(win_o) == NUM_REQ - 1) begin
            ptr_q <= '0;
         end else begin
            ptr_q <= win_o + GID_W'(1);
         end
      end
   end
`else
   // Fixed priority: the lowest set request index wins.
   always_comb begin
      valid_o = 1'b0;
      win_o   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!valid_o && req_i[k]) begin
            valid_o = 1'b1;
            win_o   = k[GID_W-1:0];
         end
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the PSRAM controller between NUM_REQ requesters on the
// clkRAM domain. Latches the winner's command, drives CE until the controller
// reports busy, waits for busy to fall, then pulses a one-cycle ack.
// Build option MEM_ARB_ROUND_ROBIN_EN selects rotating priority (see
// mem_arb_select); undefined gives fixed priority with index 0 highest.
//
// Handshake: a requester raises req with its command and holds both until it
// sees its ack bit high for one cycle; it drops req on the edge ending that
// cycle. Toward the controller, mem_ce is held with a stable command until
// mem_busy rises (accepted), and the result is valid when mem_busy falls.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int NUM_REQ       = 3,
   parameter int ISSUE_TIMEOUT = 16,
   parameter int TO_W          = 5
)
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        we,
   input  logic [NUM_REQ*BANK_W-1:0] bank,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rdata,
   output logic [GID_W-1:0]          grant_id,
   output logic                      timeout_err,
   output logic                      mem_ce,
   output logic                      mem_write,
   output logic [BANK_W-1:0]         mem_bank,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      mem_busy,
   output logic [1:0]                dbg_state
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ISSUE_TIMEOUT - 1);

   arb_state_t          state_q;
   logic [TO_W-1:0]     cnt_q;
   logic [TO_W-1:0]     cnt_d;
   logic [NUM_REQ-1:0]  ack_q;
   logic [NUM_REQ-1:0]  gnt_onehot;
   logic [DATA_W-1:0]   rdata_q;
   logic [GID_W-1:0]    grant_id_q;
   logic                timeout_err_q;
   logic                mem_ce_q;
   logic                mem_write_q;
   logic [BANK_W-1:0]   mem_bank_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   logic                sel_valid;
   logic [GID_W-1:0]    sel_id;
   logic                grant_go;
   logic                sel_we;
   logic [BANK_W-1:0]   sel_bank;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   mem_arb_select #(
      .NUM_REQ (NUM_REQ)
   ) u_select (
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .clk     (clk),
      .reset   (reset),
      .grant_i (grant_go),
`endif
      .req_i   (req),
      .valid_o (sel_valid),
      .win_o   (sel_id)
   );

   // A grant happens only from IDLE while the controller is not busy.
   assign grant_go = (state_q == ST_IDLE) && !mem_busy && sel_valid;
   assign cnt_d    = cnt_q + TO_W'(1);

   // Pick the winner's command fields out of the packed requester buses.
   always_comb begin
      sel_we    = 1'b0;
      sel_bank  = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel_id == i[GID_W-1:0]) begin
            sel_we    = we[i];
            sel_bank  = bank[i*BANK_W +: BANK_W];
            sel_addr  = addr[i*ADDR_W +: ADDR_W];
            sel_wdata = wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // One-hot ack pattern for the latched grant.
   always_comb begin
      gnt_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt_onehot[i] = (grant_id_q == i[GID_W-1:0]);
      end
   end

   // Arbitration / issue / wait / done sequencer with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         ack_q         <= '0;
         rdata_q       <= '0;
         grant_id_q    <= '0;
         timeout_err_q <= 1'b0;
         mem_ce_q      <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_bank_q    <= '0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
      end else begin
         ack_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (grant_go) begin
                  grant_id_q  <= sel_id;
                  mem_write_q <= sel_we;
                  mem_bank_q  <= sel_bank;
                  mem_addr_q  <= sel_addr;
                  mem_wdata_q <= sel_wdata;
                  mem_ce_q    <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (mem_busy) begin
                  mem_ce_q <= 1'b0;
                  state_q  <= ST_WAIT;
               end else if (cnt_q == TO_LAST) begin
                  mem_ce_q      <= 1'b0;
                  timeout_err_q <= 1'b1;
                  rdata_q       <= TIMEOUT_RDATA;
                  ack_q         <= gnt_onehot;
                  state_q       <= ST_DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_WAIT: begin
               if (!mem_busy) begin
                  if (!mem_write_q) begin
                     rdata_q <= mem_rdata;
                  end
                  ack_q   <= gnt_onehot;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack         = ack_q;
   assign rdata       = rdata_q;
   assign grant_id    = grant_id_q;
   assign timeout_err = timeout_err_q;
   assign mem_ce      = mem_ce_q;
   assign mem_write   = mem_write_q;
   assign mem_bank    = mem_bank_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized requester traffic against a behavioural PSRAM
// controller; expected responses come from a priority/memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int N     = 3;
   localparam int CMD_W = 31;             // {we, bank[6], addr[16], wdata[8]}
   localparam int EXP_W = 2 + CMD_W + 8;  // {gid, cmd, rdata}

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]   req   = '0;
   logic [N-1:0]   we    = '0;
   logic [N*6-1:0] bank  = '0;
   logic [N*16-1:0] addr = '0;
   logic [N*8-1:0] wdata = '0;
   logic [N-1:0]   ack;
   logic [7:0]     rdata;
   logic [1:0]     grant_id;
   logic           timeout_err;
   logic           mem_ce;
   logic           mem_write;
   logic [5:0]     mem_bank;
   logic [15:0]    mem_addr;
   logic [7:0]     mem_wdata;
   logic [7:0]     mem_rdata = '0;
   logic           mem_busy;
   logic [1:0]     dbg_state;

   logic init_busy = 1'b0;
   logic ctl_busy  = 1'b0;
   assign mem_busy = init_busy | ctl_busy;

   mem_arbiter #(.NUM_REQ(N), .ISSUE_TIMEOUT(16), .TO_W(5)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .bank(bank), .addr(addr),
      .wdata(wdata), .ack(ack), .rdata(rdata), .grant_id(grant_id),
      .timeout_err(timeout_err), .mem_ce(mem_ce), .mem_write(mem_write),
      .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_busy(mem_busy), .dbg_state(dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [EXP_W-1:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] init_data(input int key);
      logic [31:0] h;
      h = key * 32'h9E37_79B1;
      return h[31:24] ^ h[7:0];
   endfunction

   // ---------------- controller model ----------------
   logic           no_busy   = 1'b0;
   logic           long_busy = 1'b0;
   logic [7:0]     ctl_mem [int];
   logic [CMD_W-1:0] cap_cmd = '0;
   logic           ce_prev = 1'b0;
   int             ph = 0, dly = 0, bcnt = 0, ce_run = 0, last_ce_len = 0;

   always @(negedge clk) begin
      int key;
      if (mem_ce) ce_run++;
      else if (ce_run != 0) begin
         last_ce_len = ce_run;
         ce_run = 0;
      end
      if (reset) begin
         ctl_busy = 1'b0;
         ph = 0;
         ce_prev = 1'b0;
         ce_run = 0;
      end else begin
         if (mem_ce && !ce_prev) begin
            cap_cmd = {mem_write, mem_bank, mem_addr, mem_wdata};
            if (!no_busy && ph == 0) begin
               ph = 1;
               dly = $urandom_range(0, 3);
            end
         end
         ce_prev = mem_ce;
         case (ph)
            1: begin
               if (dly == 0) begin
                  ctl_busy = 1'b1;
                  bcnt = long_busy ? 40 : $urandom_range(1, 4);
                  ph = 2;
               end else dly--;
            end
            2: begin
               bcnt--;
               if (bcnt == 0) begin
                  key = int'(cap_cmd[29:8]);
                  if (cap_cmd[30]) begin
                     ctl_mem[key] = cap_cmd[7:0];
                     mem_rdata = 8'($urandom);
                  end else begin
                     mem_rdata = ctl_mem.exists(key) ? ctl_mem[key] : init_data(key);
                  end
                  ctl_busy = 1'b0;
                  ph = 0;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- requester driver ----------------
   logic [CMD_W-1:0] tx_cmd [N][2];
   int tx_n [N];
   int tx_i [N];
   int launch_id = 0;
   int seen_launch = 0;

   task automatic present(input int i);
      logic [CMD_W-1:0] c;
      if (tx_i[i] < tx_n[i]) begin
         c = tx_cmd[i][tx_i[i]];
         req[i] = 1'b1;
         we[i] = c[30];
         bank[i*6 +: 6] = c[29:24];
         addr[i*16 +: 16] = c[23:8];
         wdata[i*8 +: 8] = c[7:0];
      end else begin
         req[i] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (launch_id != seen_launch) begin
         seen_launch = launch_id;
         for (int i = 0; i < N; i++) begin
            tx_i[i] = 0;
            present(i);
         end
      end else if (!reset) begin
         for (int i = 0; i < N; i++) begin
            if (ack[i]) begin
               tx_i[i]++;
               present(i);
            end
         end
      end
      // Idle requesters wiggle their command fields; the arbiter must ignore them.
      for (int i = 0; i < N; i++) begin
         if (!req[i]) begin
            we[i] = 1'($urandom_range(0, 1));
            bank[i*6 +: 6] = 6'($urandom);
            addr[i*16 +: 16] = 16'($urandom);
            wdata[i*8 +: 8] = 8'($urandom);
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [EXP_W-1:0] e;
      logic [N-1:0] ea;
      int g;
      if (!reset && ack != '0) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ack: got ack=%b expected none (t=%0t)", ack, $time);
         end else begin
            e = exp_q.pop_front();
            g = int'(e[40:39]);
            ea = '0;
            ea[g] = 1'b1;
            check("ack", ack, ea);
            check("rdata", rdata, e[7:0]);
            check("grant_id", grant_id, e[40:39]);
            check("mem_cmd", cap_cmd, e[38:8]);
         end
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [int];
   int         m_ptr = 0;
   logic [7:0] m_last_rd = 8'h00;

   function automatic logic [7:0] ref_read(input int key);
      return ref_mem.exists(key) ? ref_mem[key] : init_data(key);
   endfunction

   task automatic model_reset();
      m_ptr = 0;
      m_last_rd = 8'h00;
   endtask

   // Service order: each requester's transactions in sequence; among pending
   // requesters the priority rule decides. Then hand the batch to the driver.
   task automatic launch();
      int rem [N];
      int pos [N];
      int g;
      int j;
      int key;
      logic [CMD_W-1:0] c;
      logic [7:0] rd;
      logic [1:0] g2;
      for (int i = 0; i < N; i++) begin
         rem[i] = tx_n[i];
         pos[i] = 0;
      end
      while (rem[0] + rem[1] + rem[2] > 0) begin
         g = -1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (g < 0 && rem[j] > 0) g = j;
         end
         m_ptr = (g + 1) % N;
`else
         for (int k = 0; k < N; k++) begin
            j = k;
            if (g < 0 && rem[j] > 0) g = j;
         end
`endif
         c = tx_cmd[g][pos[g]];
         pos[g]++;
         rem[g]--;
         key = int'(c[29:8]);
         if (no_busy) rd = 8'hFF;
         else if (c[30]) begin
            ref_mem[key] = c[7:0];
            rd = m_last_rd;
         end else rd = ref_read(key);
         m_last_rd = rd;
         g2 = g[1:0];
         exp_q.push_back({g2, c, rd});
      end
      @(posedge clk);
      #1 launch_id++;
   endtask

   function automatic logic [CMD_W-1:0] rand_cmd();
      logic [15:0] a;
      logic [5:0] b;
      case ($urandom_range(0, 3))
         0: a = 16'h0400;
         1: a = 16'hD020;
         2: a = 16'hFFFF;
         default: a = 16'($urandom);
      endcase
      b = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'h00;
      return {1'($urandom_range(0, 1)), b, a, 8'($urandom)};
   endfunction

   task automatic clear_tx();
      for (int i = 0; i < N; i++) tx_n[i] = 0;
   endtask

   function automatic bit all_done();
      for (int i = 0; i < N; i++) if (tx_i[i] < tx_n[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_done(input int budget);
      int c;
      c = 0;
      @(negedge clk);
      #1;
      while (!all_done() && c < budget) begin
         @(negedge clk);
         #1;
         c++;
      end
      if (!all_done()) begin
         n_vec++;
         n_err++;
         $display("FAIL batch_done: got incomplete after %0d cycles expected all acked", budget);
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
      check("exp_q_empty", exp_q.size(), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int ce_seen;
      int cnt;
      int r;
      // Reset state while the controller is still initialising.
      init_busy = 1'b1;
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         tx_n[i] = 0;
         tx_i[i] = 0;
      end
      repeat (3) @(negedge clk);
      check("rst_ack", ack, 0);
      check("rst_rdata", rdata, 0);
      check("rst_grant_id", grant_id, 0);
      check("rst_timeout_err", timeout_err, 0);
      check("rst_mem_ce", mem_ce, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_bank", mem_bank, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_state", dbg_state, 0);

      // Power-up: CPU write pending throughout the controller's init busy.
      model_reset();
      clear_tx();
      tx_n[1] = 1;
      tx_cmd[1][0] = {1'b1, 6'h00, 16'hD020, 8'h0E};
      launch();
      @(posedge clk);
      #1 reset = 1'b0;
      ce_seen = 0;
      repeat (15000) begin
         @(negedge clk);
         if (mem_ce) ce_seen++;
      end
      check("ce_during_init", ce_seen, 0);
      check("grant_during_init", grant_id, 0);
      init_busy = 1'b0;
      @(negedge clk);
      check("first_grant_id", grant_id, 1);
      check("first_mem_ce", mem_ce, 1);
      check("first_mem_write", mem_write, 1);
      check("first_mem_addr", mem_addr, 16'hD020);
      check("first_mem_wdata", mem_wdata, 8'h0E);
      wait_done(200);

      // VIC read of a location the CPU has just written.
      clear_tx();
      tx_n[1] = 1;
      tx_cmd[1][0] = {1'b1, 6'h00, 16'h0400, 8'h5A};
      launch();
      wait_done(200);
      clear_tx();
      tx_n[0] = 1;
      tx_cmd[0][0] = {1'b0, 6'h00, 16'h0400, 8'h00};
      launch();
      wait_done(200);

      // All three requesting at once, VIC holding req for a second access.
      clear_tx();
      tx_n[0] = 2;
      tx_n[1] = 1;
      tx_n[2] = 1;
      tx_cmd[0][0] = rand_cmd();
      tx_cmd[0][1] = rand_cmd();
      tx_cmd[1][0] = rand_cmd();
      tx_cmd[2][0] = rand_cmd();
      launch();
      wait_done(300);

      // Random batches.
      for (int b = 0; b < 30; b++) begin
         clear_tx();
         cnt = 0;
         for (int i = 0; i < N; i++) begin
            tx_n[i] = $urandom_range(0, 2);
            cnt += tx_n[i];
            tx_cmd[i][0] = rand_cmd();
            tx_cmd[i][1] = rand_cmd();
         end
         if (cnt == 0) tx_n[$urandom_range(0, 2)] = 1;
         launch();
         wait_done(300);
      end

      // Controller never accepts: CE held 16 cycles, then timeout ack.
      no_busy = 1'b1;
      clear_tx();
      r = $urandom_range(0, 2);
      tx_n[r] = 1;
      tx_cmd[r][0] = rand_cmd();
      launch();
      wait_done(200);
      check("timeout_ce_len", last_ce_len, 16);
      check("timeout_err_set", timeout_err, 1);
      no_busy = 1'b0;

      // Sticky flag survives normal traffic.
      clear_tx();
      tx_n[2] = 1;
      tx_n[1] = 1;
      tx_cmd[2][0] = rand_cmd();
      tx_cmd[1][0] = rand_cmd();
      launch();
      wait_done(200);
      check("timeout_err_sticky", timeout_err, 1);

      // Reset asserted while the controller is busy (arbiter waiting).
      long_busy = 1'b1;
      clear_tx();
      tx_n[2] = 1;
      tx_cmd[2][0] = {1'b0, 6'h3F, 16'h1234, 8'h00};
      launch();
      cnt = 0;
      while (!ctl_busy && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check("busy_seen_before_reset", ctl_busy, 1);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_mem_ce", mem_ce, 0);
      check("midrst_ack", ack, 0);
      check("midrst_timeout_err", timeout_err, 0);
      check("midrst_grant_id", grant_id, 0);
      check("midrst_rdata", rdata, 0);
      exp_q.delete();
      long_busy = 1'b0;
      model_reset();
      clear_tx();
      launch();
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);

      // Normal service after the aborted transaction.
      for (int b = 0; b < 8; b++) begin
         clear_tx();
         for (int i = 0; i < N; i++) begin
            tx_n[i] = $urandom_range(0, 2);
            tx_cmd[i][0] = rand_cmd();
            tx_cmd[i][1] = rand_cmd();
         end
         tx_n[b % N] = 1;
         launch();
         wait_done(300);
      end
      check("timeout_err_after_reset", timeout_err, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global bound on the run.
   initial begin
      #5ms;
      n_err++;
      $display("FAIL watchdog: got no completion expected finish before 5ms");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
